svk_ahb_arbiter_mux: RTL and testbench

//  Multi-master AHB arbiter and address/write-data multiplexer.

---
 rtl/svk_ahb_arbiter_mux.sv | 152 +++++++++++++++
 tb/tb_svk_ahb_arbiter_mux.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/svk_ahb_arbiter_mux.sv
// rtl/svk_ahb_arbiter_mux.sv - multi-master AHB arbiter with address/control and write-data muxing
module svk_ahb_arbiter_mux #(
    parameter int NUM_MASTER     = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int DEFAULT_MASTER = 0,
    localparam int MW            = $clog2(NUM_MASTER)
) (
    input  logic                         hclk,
    input  logic                         hresetn,
    input  logic [NUM_MASTER-1:0]        m_hbusreq,
    input  logic [NUM_MASTER-1:0]        m_hlock,
    input  logic [2*NUM_MASTER-1:0]      m_htrans,
    input  logic [ADDR_W*NUM_MASTER-1:0] m_haddr,
    input  logic [NUM_MASTER-1:0]        m_hwrite,
    input  logic [3*NUM_MASTER-1:0]      m_hsize,
    input  logic [3*NUM_MASTER-1:0]      m_hburst,
    input  logic [DATA_W*NUM_MASTER-1:0] m_hwdata,
    output logic [NUM_MASTER-1:0]        m_hgrant,
    input  logic                         hready,
    output logic [1:0]                   s_htrans,
    output logic [ADDR_W-1:0]            s_haddr,
    output logic                         s_hwrite,
    output logic [2:0]                   s_hsize,
    output logic [2:0]                   s_hburst,
    output logic [DATA_W-1:0]            s_hwdata,
    output logic                         s_hmastlock,
    output logic [MW-1:0]                s_hmaster
);

    localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_BUSY   = 2'b01;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    localparam logic [2:0] HB_SINGLE = 3'b000;
    localparam logic [2:0] HB_INCR   = 3'b001;
    localparam logic [2:0] HB_WRAP4  = 3'b010;
    localparam logic [2:0] HB_INCR4  = 3'b011;
    localparam logic [2:0] HB_WRAP8  = 3'b100;
    localparam logic [2:0] HB_INCR8  = 3'b101;
    localparam logic [2:0] HB_WRAP16 = 3'b110;
    localparam logic [2:0] HB_INCR16 = 3'b111;

    logic [1:0]        trans_a [NUM_MASTER];
    logic [ADDR_W-1:0] addr_a  [NUM_MASTER];
    logic [2:0]        size_a  [NUM_MASTER];
    logic [2:0]        burst_a [NUM_MASTER];
    logic [DATA_W-1:0] wdata_a [NUM_MASTER];

    logic [MW-1:0] grant_q;
    logic [MW-1:0] addr_own;
    logic [MW-1:0] data_own;
    logic          lock_q;
    logic [3:0]    beat_cnt;

    logic [1:0]    own_htrans;
    logic [2:0]    own_hburst;
    logic          burst_last;
    logic          handover;
    logic [MW-1:0] rr_pick;
    logic          rr_found;

    for (genvar i = 0; i < NUM_MASTER; i++) begin : g_unpack
        assign trans_a[i] = m_htrans[2*i +: 2];
        assign addr_a[i]  = m_haddr[ADDR_W*i +: ADDR_W];
        assign size_a[i]  = m_hsize[3*i +: 3];
        assign burst_a[i] = m_hburst[3*i +: 3];
        assign wdata_a[i] = m_hwdata[DATA_W*i +: DATA_W];
    end

    assign own_htrans = trans_a[addr_own];
    assign own_hburst = burst_a[addr_own];

    // Address-phase mux follows addr_own; HTRANS is held at IDLE while in reset.
    assign s_htrans    = hresetn ? own_htrans : HT_IDLE;
    assign s_haddr     = addr_a[addr_own];
    assign s_hwrite    = m_hwrite[addr_own];
    assign s_hsize     = size_a[addr_own];
    assign s_hburst    = own_hburst;
    assign s_hwdata    = wdata_a[data_own];
    assign s_hmastlock = lock_q;
    assign s_hmaster   = addr_own;

    always_comb begin
        m_hgrant          = '0;
        m_hgrant[grant_q] = 1'b1;
    end

    always_comb begin
        case (own_hburst)
            HB_WRAP4, HB_INCR4:   burst_last = (beat_cnt == 4'd3);
            HB_WRAP8, HB_INCR8:   burst_last = (beat_cnt == 4'd7);
            HB_WRAP16, HB_INCR16: burst_last = (beat_cnt == 4'd15);
            default:              burst_last = 1'b0;
        endcase
    end

    assign handover = hready && !lock_q && !m_hlock[addr_own] &&
                      ((own_htrans == HT_IDLE) ||
                       (own_htrans == HT_NONSEQ && own_hburst == HB_SINGLE) ||
                       (own_htrans == HT_SEQ && burst_last) ||
                       (own_hburst == HB_INCR && !m_hbusreq[addr_own]));

    // Search starts just past the owner, so the owner itself is checked last.
    always_comb begin : rr_search
        int            cand;
        logic [MW-1:0] cand_idx;
        rr_pick  = DEF_IDX;
        rr_found = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_MASTER; k++) begin
            cand = int'(addr_own) + k;
            if (cand >= NUM_MASTER) begin
                cand = cand - NUM_MASTER;
            end
            cand_idx = cand[MW-1:0];
            if (!rr_found && m_hbusreq[cand_idx]) begin
                rr_found = 1'b1;
                rr_pick  = cand_idx;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            grant_q  <= DEF_IDX;
            addr_own <= DEF_IDX;
            data_own <= DEF_IDX;
            lock_q   <= 1'b0;
            beat_cnt <= 4'd0;
        end else if (hready) begin
            addr_own <= grant_q;
            data_own <= addr_own;
            lock_q   <= m_hlock[grant_q];
            if (handover) begin
                grant_q <= rr_pick;
            end
            case (own_htrans)
                HT_NONSEQ: beat_cnt <= 4'd1;
                HT_SEQ:    beat_cnt <= beat_cnt + 4'd1;
                HT_IDLE:   beat_cnt <= 4'd0;
                HT_BUSY:   beat_cnt <= beat_cnt;
                default:   beat_cnt <= beat_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_svk_ahb_arbiter_mux.sv
// tb/tb_svk_ahb_arbiter_mux.sv - self-checking bench for svk_ahb_arbiter_mux
module tb_svk_ahb_arbiter_mux;

    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 2;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'd0;
    localparam logic [2:0] B_INCR4  = 3'd3;
    localparam logic [2:0] B_WRAP8  = 3'd4;

    logic              hclk = 1'b0;
    logic              hresetn;
    logic              hready;
    logic [NM-1:0]     m_hbusreq, m_hlock, m_hwrite, m_hgrant;
    logic [2*NM-1:0]   m_htrans;
    logic [AW*NM-1:0]  m_haddr;
    logic [3*NM-1:0]   m_hsize, m_hburst;
    logic [DW*NM-1:0]  m_hwdata;
    logic [1:0]        s_htrans;
    logic [AW-1:0]     s_haddr;
    logic              s_hwrite;
    logic [2:0]        s_hsize, s_hburst;
    logic [DW-1:0]     s_hwdata;
    logic              s_hmastlock;
    logic [MW-1:0]     s_hmaster;

    logic          req_a   [NM];
    logic          lock_a  [NM];
    logic          write_a [NM];
    logic [1:0]    trans_a [NM];
    logic [AW-1:0] addr_a  [NM];
    logic [2:0]    size_a  [NM];
    logic [2:0]    burst_a [NM];
    logic [DW-1:0] wdata_a [NM];

    int mdl_grant, mdl_addr, mdl_data, mdl_lock, mdl_beat;
    int n_checks = 0;
    int n_fail   = 0;

    for (genvar i = 0; i < NM; i++) begin : g_pack
        assign m_hbusreq[i]         = req_a[i];
        assign m_hlock[i]           = lock_a[i];
        assign m_hwrite[i]          = write_a[i];
        assign m_htrans[2*i +: 2]   = trans_a[i];
        assign m_haddr[AW*i +: AW]  = addr_a[i];
        assign m_hsize[3*i +: 3]    = size_a[i];
        assign m_hburst[3*i +: 3]   = burst_a[i];
        assign m_hwdata[DW*i +: DW] = wdata_a[i];
    end

    svk_ahb_arbiter_mux #(
        .NUM_MASTER(NM), .ADDR_W(AW), .DATA_W(DW), .DEFAULT_MASTER(0)
    ) dut (
        .hclk(hclk), .hresetn(hresetn),
        .m_hbusreq(m_hbusreq), .m_hlock(m_hlock), .m_htrans(m_htrans),
        .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
        .m_hburst(m_hburst), .m_hwdata(m_hwdata), .m_hgrant(m_hgrant),
        .hready(hready), .s_htrans(s_htrans), .s_haddr(s_haddr),
        .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
        .s_hwdata(s_hwdata), .s_hmastlock(s_hmastlock), .s_hmaster(s_hmaster)
    );

    always #5 hclk = ~hclk;

    function automatic int burst_len(logic [2:0] b);
        case (b)
            3'd0:       return 1;
            3'd1:       return 0;
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            default:    return 16;
        endcase
    endfunction

    function automatic int oh_idx(logic [NM-1:0] v);
        for (int i = 0; i < NM; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        mdl_grant = 0; mdl_addr = 0; mdl_data = 0; mdl_lock = 0; mdl_beat = 0;
    endtask

    // Reference behaviour for one rising edge, using the inputs presented before it.
    task automatic model_step();
        int  own, bl, nxt;
        bit  ok;
        if (!hresetn) begin
            model_reset();
            return;
        end
        if (!hready) return;
        own = mdl_addr;
        bl  = burst_len(burst_a[own]);
        ok  = (mdl_lock == 0) && !lock_a[own] &&
              ((trans_a[own] == T_IDLE) ||
               (trans_a[own] == T_NSEQ && bl == 1) ||
               (trans_a[own] == T_SEQ && bl > 1 && mdl_beat == bl - 1) ||
               (bl == 0 && !req_a[own]));
        nxt = mdl_grant;
        if (ok) begin
            nxt = 0;
            for (int k = 1; k <= NM; k++) begin
                if (req_a[(own + k) % NM]) begin
                    nxt = (own + k) % NM;
                    break;
                end
            end
        end
        mdl_lock = lock_a[mdl_grant] ? 1 : 0;
        mdl_data = mdl_addr;
        mdl_addr = mdl_grant;
        mdl_grant = nxt;
        if (trans_a[own] == T_NSEQ)     mdl_beat = 1;
        else if (trans_a[own] == T_SEQ) mdl_beat = (mdl_beat + 1) % 16;
        else if (trans_a[own] == T_IDLE) mdl_beat = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge hclk);
        #1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NM; i++) begin
            req_a[i] = 1'b0; lock_a[i] = 1'b0; write_a[i] = 1'b0;
            trans_a[i] = T_IDLE; addr_a[i] = AW'(32'h1000 * (i + 1));
            size_a[i] = 3'd2; burst_a[i] = B_SINGLE;
            wdata_a[i] = DW'(32'hC0DE_0000 + i);
        end
    endtask

    task automatic test_reset();
        hresetn = 1'b0; hready = 1'b1;
        idle_all();
        trans_a[0] = T_NSEQ; req_a[2] = 1'b1; lock_a[0] = 1'b1;
        model_reset();
        repeat (3) tick();
        n_checks++; if (m_hgrant !== 4'b0001) begin n_fail++; $display("FAIL reset_grant got %b want 0001", m_hgrant); end
        n_checks++; if (s_hmaster !== 2'd0) begin n_fail++; $display("FAIL reset_hmaster got %0d want 0", s_hmaster); end
        n_checks++; if (s_hmastlock !== 1'b0) begin n_fail++; $display("FAIL reset_mastlock got %b want 0", s_hmastlock); end
        n_checks++; if (s_htrans !== T_IDLE) begin n_fail++; $display("FAIL reset_htrans got %b want 00", s_htrans); end
        hresetn = 1'b1;
        idle_all();
        repeat (2) tick();
    endtask

    task automatic test_grant();
        req_a[2] = 1'b1;
        #1;
        n_checks++; if (m_hgrant !== 4'b0001) begin n_fail++; $display("FAIL grant_early got %b want 0001", m_hgrant); end
        tick();
        n_checks++; if (m_hgrant !== 4'b0100) begin n_fail++; $display("FAIL grant_m2 got %b want 0100", m_hgrant); end
        trans_a[2] = T_NSEQ; addr_a[2] = 32'h100; write_a[2] = 1'b1; wdata_a[2] = 32'hA5A5_0002;
        tick();
        n_checks++; if (s_hmaster !== 2'd2) begin n_fail++; $display("FAIL grant_hmaster got %0d want 2", s_hmaster); end
        n_checks++; if (s_haddr !== 32'h100) begin n_fail++; $display("FAIL grant_haddr got %h want 00000100", s_haddr); end
        n_checks++; if (s_htrans !== T_NSEQ) begin n_fail++; $display("FAIL grant_htrans got %b want 10", s_htrans); end
        tick();
        trans_a[2] = T_IDLE; req_a[2] = 1'b0;
        n_checks++; if (s_hwdata !== 32'hA5A5_0002) begin n_fail++; $display("FAIL grant_hwdata got %h want a5a50002", s_hwdata); end
        idle_all();
        repeat (3) tick();
    endtask

    task automatic test_round_robin();
        int seq[$];
        int exp_seq[4] = '{1, 3, 1, 3};
        int last, got;
        req_a[1] = 1'b1; req_a[3] = 1'b1;
        trans_a[1] = T_NSEQ; trans_a[3] = T_NSEQ;
        last = oh_idx(m_hgrant);
        for (int c = 0; c < 16; c++) begin
            tick();
            if (oh_idx(m_hgrant) != last) begin
                last = oh_idx(m_hgrant);
                seq.push_back(last);
            end
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < seq.size()) ? seq[i] : -1;
            n_checks++;
            if (got != exp_seq[i]) begin n_fail++; $display("FAIL rr_order[%0d] got %0d want %0d", i, got, exp_seq[i]); end
        end
        idle_all();
        repeat (3) tick();
    endtask

    task automatic test_burst_hold();
        req_a[1] = 1'b1;
        tick();
        trans_a[1] = T_NSEQ; burst_a[1] = B_INCR4; addr_a[1] = 32'h200; write_a[1] = 1'b1;
        tick();
        req_a[2] = 1'b1;
        for (int b = 1; b <= 3; b++) begin
            tick();
            n_checks++; if (m_hgrant !== 4'b0010) begin n_fail++; $display("FAIL burst_hold beat%0d got %b want 0010", b, m_hgrant); end
            trans_a[1] = T_SEQ; addr_a[1] = AW'(32'h200 + 4 * b);
        end
        tick();
        n_checks++; if (m_hgrant !== 4'b0100) begin n_fail++; $display("FAIL burst_release got %b want 0100", m_hgrant); end
        trans_a[1] = T_IDLE; req_a[1] = 1'b0;
        trans_a[2] = T_NSEQ; addr_a[2] = 32'h300;
        n_checks++; if (s_hmaster !== 2'd1) begin n_fail++; $display("FAIL burst_owner_pre got %0d want 1", s_hmaster); end
        tick();
        n_checks++; if (s_hmaster !== 2'd2) begin n_fail++; $display("FAIL burst_owner_post got %0d want 2", s_hmaster); end
        n_checks++; if (s_haddr !== 32'h300) begin n_fail++; $display("FAIL burst_haddr got %h want 00000300", s_haddr); end
        idle_all();
        repeat (3) tick();
    endtask

    task automatic test_lock();
        bit granted;
        lock_a[0] = 1'b1; req_a[0] = 1'b1; trans_a[0] = T_NSEQ; req_a[3] = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            n_checks++; if (m_hgrant !== 4'b0001) begin n_fail++; $display("FAIL lock_grant t%0d got %b want 0001", t, m_hgrant); end
            n_checks++; if (s_hmastlock !== 1'b1) begin n_fail++; $display("FAIL lock_mastlock t%0d got %b want 1", t, s_hmastlock); end
            addr_a[0] = addr_a[0] + 32'd4;
        end
        lock_a[0] = 1'b0; req_a[0] = 1'b0; trans_a[0] = T_IDLE;
        granted = 1'b0;
        for (int t = 0; t < 4 && !granted; t++) begin
            tick();
            if (m_hgrant === 4'b1000) granted = 1'b1;
        end
        n_checks++; if (!granted) begin n_fail++; $display("FAIL lock_release got %b want 1000", m_hgrant); end
        idle_all();
        repeat (3) tick();
    endtask

    task automatic test_stall();
        req_a[1] = 1'b1; req_a[2] = 1'b1;
        tick();
        trans_a[1] = T_NSEQ; burst_a[1] = B_INCR4; addr_a[1] = 32'h400; write_a[1] = 1'b1;
        tick();
        for (int b = 1; b <= 3; b++) begin
            tick();
            trans_a[1] = T_SEQ; addr_a[1] = AW'(32'h400 + 4 * b); wdata_a[1] = DW'(32'hD000_0000 + b);
        end
        hready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            n_checks++; if (m_hgrant !== 4'b0010) begin n_fail++; $display("FAIL stall_grant s%0d got %b want 0010", s, m_hgrant); end
            n_checks++; if (s_haddr !== 32'h40C) begin n_fail++; $display("FAIL stall_haddr s%0d got %h want 0000040c", s, s_haddr); end
            n_checks++; if (s_hwdata !== 32'hD000_0003) begin n_fail++; $display("FAIL stall_hwdata s%0d got %h want d0000003", s, s_hwdata); end
        end
        hready = 1'b1;
        tick();
        n_checks++; if (m_hgrant !== 4'b0100) begin n_fail++; $display("FAIL stall_resume got %b want 0100", m_hgrant); end
        idle_all();
        repeat (3) tick();
    endtask

    task automatic test_reset_burst();
        req_a[2] = 1'b1; trans_a[0] = T_NSEQ;
        tick();
        lock_a[2] = 1'b1; trans_a[2] = T_NSEQ; burst_a[2] = B_WRAP8; addr_a[2] = 32'h500;
        tick();
        tick();
        trans_a[2] = T_SEQ; addr_a[2] = 32'h504;
        tick();
        trans_a[2] = T_SEQ; addr_a[2] = 32'h508;
        n_checks++; if (s_hmastlock !== 1'b1) begin n_fail++; $display("FAIL rb_pre_lock got %b want 1", s_hmastlock); end
        #2;
        hresetn = 1'b0;
        model_reset();
        #1;
        n_checks++; if (m_hgrant !== 4'b0001) begin n_fail++; $display("FAIL rb_grant got %b want 0001", m_hgrant); end
        n_checks++; if (s_hmaster !== 2'd0) begin n_fail++; $display("FAIL rb_hmaster got %0d want 0", s_hmaster); end
        n_checks++; if (s_hmastlock !== 1'b0) begin n_fail++; $display("FAIL rb_mastlock got %b want 0", s_hmastlock); end
        n_checks++; if (s_htrans !== T_IDLE) begin n_fail++; $display("FAIL rb_htrans got %b want 00", s_htrans); end
        tick();
        hresetn = 1'b1;
        idle_all();
        repeat (2) tick();
    endtask

    task automatic test_random();
        logic [NM-1:0] exp_grant;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NM; i++) begin
                req_a[i]   = ($urandom_range(0, 1) == 1);
                lock_a[i]  = ($urandom_range(0, 9) == 0);
                write_a[i] = ($urandom_range(0, 1) == 1);
                trans_a[i] = 2'($urandom_range(0, 3));
                burst_a[i] = 3'($urandom_range(0, 7));
                size_a[i]  = 3'($urandom_range(0, 2));
                addr_a[i]  = AW'($urandom);
                wdata_a[i] = DW'($urandom);
            end
            hready = ($urandom_range(0, 4) != 0);
            tick();
            exp_grant = NM'(1) << mdl_grant;
            n_checks++; if (m_hgrant !== exp_grant) begin n_fail++; $display("FAIL rand_grant c%0d got %b want %b", c, m_hgrant, exp_grant); end
            n_checks++; if (s_hmaster !== MW'(mdl_addr)) begin n_fail++; $display("FAIL rand_hmaster c%0d got %0d want %0d", c, s_hmaster, mdl_addr); end
            n_checks++; if (s_haddr !== addr_a[mdl_addr]) begin n_fail++; $display("FAIL rand_haddr c%0d got %h want %h", c, s_haddr, addr_a[mdl_addr]); end
            n_checks++; if (s_htrans !== trans_a[mdl_addr]) begin n_fail++; $display("FAIL rand_htrans c%0d got %b want %b", c, s_htrans, trans_a[mdl_addr]); end
            n_checks++; if (s_hwrite !== write_a[mdl_addr]) begin n_fail++; $display("FAIL rand_hwrite c%0d got %b want %b", c, s_hwrite, write_a[mdl_addr]); end
            n_checks++; if (s_hburst !== burst_a[mdl_addr]) begin n_fail++; $display("FAIL rand_hburst c%0d got %0d want %0d", c, s_hburst, burst_a[mdl_addr]); end
            n_checks++; if (s_hsize !== size_a[mdl_addr]) begin n_fail++; $display("FAIL rand_hsize c%0d got %0d want %0d", c, s_hsize, size_a[mdl_addr]); end
            n_checks++; if (s_hwdata !== wdata_a[mdl_data]) begin n_fail++; $display("FAIL rand_hwdata c%0d got %h want %h", c, s_hwdata, wdata_a[mdl_data]); end
            n_checks++; if (s_hmastlock !== (mdl_lock != 0)) begin n_fail++; $display("FAIL rand_mastlock c%0d got %b want %0d", c, s_hmastlock, mdl_lock); end
        end
        hready = 1'b1;
        idle_all();
        repeat (3) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_grant();
        test_round_robin();
        test_burst_hold();
        test_lock();
        test_stall();
        test_reset_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
